scan_sequencer: RTL and testbench

SCAN_SEQUENCER -- requirements
Module: scan_sequencer

---
 rtl/scan_sequencer.sv | 215 +++++++++++++++++++++
 tb/tb_scan_sequencer.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/scan_sequencer.sv
// -----------------------------------------------------------------------------
// scan_sequencer
//
// Round-robin lane scanner for a time-multiplexed driver. It walks the set bits
// of lane_mask from lowest to highest and presents each lane index on sel.
// sel_valid is high for DWELL cycles per lane, then low for BLANK dead-time
// cycles before the next lane. frame_done pulses for one cycle when the
// sequence wraps back to the lowest enabled lane.
//
// Parameters
//   N      : lane index width (M = 2**N lanes)
//   DWELL  : cycles sel_valid stays high per lane (1..255)
//   BLANK  : dead-time cycles between lanes (0..255)
//
// Ports
//   clk        in   single clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   en         in   scan enable; dropping it returns the block to idle
//   lane_mask  in   M bits, bit i set = lane i is scanned
//   sel        out  N bits, registered lane index for the downstream decoder
//   sel_valid  out  high while the selected lane is to be driven
//   frame_done out  one-cycle pulse when a wrap-around lane first appears
//   frame_cnt  out  8-bit frame counter (only with SCAN_SEQUENCER_FRAME_CNT_EN)
//
// Optional feature
//   SCAN_SEQUENCER_FRAME_CNT_EN : when defined, adds frame_cnt, which counts
//   frame_done pulses modulo 256 and is cleared by reset.
// -----------------------------------------------------------------------------
module scan_sequencer #(
  parameter int N     = 3,
  parameter int DWELL = 4,
  parameter int BLANK = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                en,
  input  logic [(1<<N)-1:0]   lane_mask,
  output logic [N-1:0]        sel,
  output logic                sel_valid,
`ifdef SCAN_SEQUENCER_FRAME_CNT_EN
  output logic [7:0]          frame_cnt,
`endif
  output logic                frame_done
);

  localparam int M = 1 << N;

  // Terminal counts of the shared dwell/blank counter.
  localparam logic [7:0] DWELL_LAST = 8'(DWELL - 1);
  localparam logic [7:0] BLANK_LAST = (BLANK > 0) ? 8'(BLANK - 1) : 8'd0;
  localparam logic       HAS_BLANK  = (BLANK > 0) ? 1'b1 : 1'b0;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SCAN  = 2'd1,
    ST_BLANK = 2'd2
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic [7:0]  cnt;
  logic [7:0]  cnt_nxt;
  logic [N-1:0] sel_nxt;
  logic        valid_nxt;
  logic        done_nxt;
  logic [N-1:0] low_lane;
  logic [N:0]  adv_lane;

  // Index of the lowest set bit of mask (0 when mask is empty).
  function automatic logic [N-1:0] lowest_set(input logic [M-1:0] mask);
    logic [N-1:0] idx;
    idx = '0;
    for (int i = M - 1; i >= 0; i--) begin
      if (mask[i]) begin
        idx = N'(i);
      end else begin
        idx = idx;
      end
    end
    return idx;
  endfunction

  // Next set bit strictly above cur; MSB of the result flags a wrap to the
  // lowest set bit (which includes a single-lane mask wrapping onto itself).
  function automatic logic [N:0] next_lane(input logic [M-1:0] mask,
                                           input logic [N-1:0] cur);
    logic         found;
    logic [N-1:0] idx;
    found = 1'b0;
    idx   = '0;
    for (int i = 0; i < M; i++) begin
      if (!found && mask[i] && (i > int'(cur))) begin
        found = 1'b1;
        idx   = N'(i);
      end else begin
        found = found;
      end
    end
    if (found) begin
      return {1'b0, idx};
    end else begin
      return {1'b1, lowest_set(mask)};
    end
  endfunction

  assign low_lane = lowest_set(lane_mask);
  assign adv_lane = next_lane(lane_mask, sel);

  // Next-state and next-output logic; lane_mask is only consulted at IDLE
  // exit and at lane-advance points, so mid-dwell mask edits take effect late.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    sel_nxt   = sel;
    valid_nxt = sel_valid;
    done_nxt  = 1'b0;

    case (state)
      ST_IDLE: begin
        cnt_nxt = 8'd0;
        if (en && (lane_mask != '0)) begin
          state_nxt = ST_SCAN;
          sel_nxt   = low_lane;
          valid_nxt = 1'b1;
        end else begin
          valid_nxt = 1'b0;
        end
      end

      ST_SCAN: begin
        if (!en) begin
          state_nxt = ST_IDLE;
          valid_nxt = 1'b0;
          cnt_nxt   = 8'd0;
        end else if (cnt == DWELL_LAST) begin
          cnt_nxt = 8'd0;
          if (HAS_BLANK) begin
            state_nxt = ST_BLANK;
            valid_nxt = 1'b0;
          end else if (lane_mask == '0) begin
            state_nxt = ST_IDLE;
            valid_nxt = 1'b0;
          end else begin
            // BLANK=0: hop straight to the next lane, sel_valid stays high.
            state_nxt = ST_SCAN;
            sel_nxt   = adv_lane[N-1:0];
            valid_nxt = 1'b1;
            done_nxt  = adv_lane[N];
          end
        end else begin
          cnt_nxt = cnt + 8'd1;
        end
      end

      ST_BLANK: begin
        if (!en) begin
          state_nxt = ST_IDLE;
          valid_nxt = 1'b0;
          cnt_nxt   = 8'd0;
        end else if (cnt == BLANK_LAST) begin
          cnt_nxt = 8'd0;
          if (lane_mask == '0) begin
            state_nxt = ST_IDLE;
            valid_nxt = 1'b0;
          end else begin
            state_nxt = ST_SCAN;
            sel_nxt   = adv_lane[N-1:0];
            valid_nxt = 1'b1;
            done_nxt  = adv_lane[N];
          end
        end else begin
          cnt_nxt = cnt + 8'd1;
        end
      end

      default: begin
        state_nxt = ST_IDLE;
        valid_nxt = 1'b0;
        cnt_nxt   = 8'd0;
      end
    endcase
  end

  // State, counter and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      cnt        <= 8'd0;
      sel        <= '0;
      sel_valid  <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      sel        <= sel_nxt;
      sel_valid  <= valid_nxt;
      frame_done <= done_nxt;
    end
  end

`ifdef SCAN_SEQUENCER_FRAME_CNT_EN
  // Frame counter steps on the same edge that raises frame_done, so the new
  // count appears together with the pulse; wraps naturally at 8 bits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_cnt <= 8'd0;
    end else if (done_nxt) begin
      frame_cnt <= frame_cnt + 8'd1;
    end else begin
      frame_cnt <= frame_cnt;
    end
  end
`endif

endmodule

// File: tb/tb_scan_sequencer.sv
// -----------------------------------------------------------------------------
// tb_scan_sequencer
//
// Self-checking bench for scan_sequencer (N=2, DWELL=3, BLANK=1). A reference
// model tracks "which lane, how old is it in its DWELL+BLANK slot, is the
// scanner on" and predicts sel / sel_valid / frame_done every cycle. Directed
// phases cover the listed scenarios; a randomized phase follows.
// -----------------------------------------------------------------------------
module tb_scan_sequencer;

  localparam int N     = 2;
  localparam int DWELL = 3;
  localparam int BLANK = 1;
  localparam int M     = 1 << N;
  localparam int SLOT  = DWELL + BLANK;

  logic         clk;
  logic         rst_n;
  logic         en;
  logic [M-1:0] lane_mask;
  logic [N-1:0] sel;
  logic         sel_valid;
  logic         frame_done;
`ifdef SCAN_SEQUENCER_FRAME_CNT_EN
  logic [7:0]   frame_cnt;
`endif

  scan_sequencer #(.N(N), .DWELL(DWELL), .BLANK(BLANK)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .lane_mask  (lane_mask),
    .sel        (sel),
    .sel_valid  (sel_valid),
`ifdef SCAN_SEQUENCER_FRAME_CNT_EN
    .frame_cnt  (frame_cnt),
`endif
    .frame_done (frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  // reference model
  bit   m_on;
  int   m_lane;
  int   m_age;
  bit   m_done;
  int   m_fcnt;

  // observations of DUT frame pulses
  int last_done;
  int period;
  int nfr;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s cycle %0d: got %0d expected %0d", tag, cyc, got, exp);
    end
  endtask

  task automatic model_reset();
    m_on   = 1'b0;
    m_lane = 0;
    m_age  = 0;
    m_done = 1'b0;
    m_fcnt = 0;
  endtask

  // Advance the model by one clock edge using the inputs seen at that edge.
  task automatic model_update();
    int nxt;
    if (!rst_n) begin
      model_reset();
      return;
    end
    m_done = 1'b0;
    if (!en) begin
      m_on = 1'b0;
    end else if (!m_on) begin
      if (lane_mask != 0) begin
        nxt = -1;
        for (int i = 0; i < M; i++) if (lane_mask[i] && nxt < 0) nxt = i;
        m_on   = 1'b1;
        m_lane = nxt;
        m_age  = 0;
      end
    end else if (m_age == SLOT - 1) begin
      if (lane_mask == 0) begin
        m_on = 1'b0;
      end else begin
        nxt = -1;
        for (int i = m_lane + 1; i < M; i++) if (lane_mask[i] && nxt < 0) nxt = i;
        if (nxt < 0) begin
          m_done = 1'b1;
          for (int i = 0; i < M; i++) if (lane_mask[i] && nxt < 0) nxt = i;
        end
        m_lane = nxt;
        m_age  = 0;
      end
    end else begin
      m_age++;
    end
    if (m_done) m_fcnt = (m_fcnt + 1) % 256;
  endtask

  task automatic compare_all();
    check("sel",        32'(sel),        32'(m_lane));
    check("sel_valid",  32'(sel_valid),  32'(m_on && (m_age < DWELL)));
    check("frame_done", 32'(frame_done), 32'(m_done));
`ifdef SCAN_SEQUENCER_FRAME_CNT_EN
    check("frame_cnt",  32'(frame_cnt),  32'(m_fcnt));
`endif
  endtask

  task automatic step();
    @(posedge clk);
    cyc++;
    model_update();
    #1;
    compare_all();
    if (frame_done) begin
      if (last_done >= 0) period = cyc - last_done;
      last_done = cyc;
      nfr++;
    end
  endtask

  task automatic run(input int n);
    for (int k = 0; k < n; k++) step();
  endtask

  int bad_lane;
  bit found;

  initial begin
    rst_n = 1'b0;
    en = 1'b0;
    lane_mask = '0;
    model_reset();
    last_done = -1;
    period = 0;
    nfr = 0;

    #12;
    compare_all();
    run(2);
    rst_n = 1'b1;
    run(3);

    // all four lanes: 0,1,2,3 with 16-cycle frame
    en = 1'b1;
    lane_mask = 4'b1111;
    last_done = -1;
    run(40);
    check("period_1111", 32'(period), 32'd16);

    // lanes 1 and 3 only: 8-cycle frame, lanes 0/2 never driven
    lane_mask = 4'b1010;
    run(10);
    last_done = -1;
    period = 0;
    bad_lane = 0;
    for (int k = 0; k < 30; k++) begin
      step();
      if (sel_valid && (sel == 2'd0 || sel == 2'd2)) bad_lane++;
    end
    check("period_1010", 32'(period), 32'd8);
    check("lanes_0_2", 32'(bad_lane), 32'd0);

    // empty mask parks the scanner, a new mask restarts it next edge
    lane_mask = '0;
    run(12);
    check("idle_valid", 32'(sel_valid), 32'd0);
    lane_mask = 4'b0100;
    step();
    check("idle_exit_sel", 32'(sel), 32'd2);
    check("idle_exit_valid", 32'(sel_valid), 32'd1);

    // drop en on dwell cycle 2 of lane 2
    step();
    en = 1'b0;
    step();
    check("en_drop_valid", 32'(sel_valid), 32'd0);
    check("en_drop_sel", 32'(sel), 32'd2);
    run(3);
    lane_mask = 4'b0110;
    en = 1'b1;
    for (int k = 0; k < DWELL; k++) begin
      step();
      check("reen_sel", 32'(sel), 32'd1);
      check("reen_valid", 32'(sel_valid), 32'd1);
    end
    step();
    check("reen_blank", 32'(sel_valid), 32'd0);

    // asynchronous reset in the middle of a blank cycle
    lane_mask = 4'b1111;
    found = 1'b0;
    for (int k = 0; k < 20 && !found; k++) begin
      step();
      if (m_on && m_age >= DWELL && m_lane != 0) found = 1'b1;
    end
    check("reached_blank", 32'(found), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check("async_rst_sel", 32'(sel), 32'd0);
    check("async_rst_valid", 32'(sel_valid), 32'd0);
    check("async_rst_done", 32'(frame_done), 32'd0);
    run(2);
    rst_n = 1'b1;

    // single lane: its own wrap, pulse every DWELL+BLANK cycles
    lane_mask = 4'b0001;
    last_done = -1;
    period = 0;
    nfr = 0;
    for (int k = 0; k < 1100 && nfr < 256; k++) step();
    check("frames_256", 32'(nfr), 32'd256);
    check("period_0001", 32'(period), 32'(SLOT));
`ifdef SCAN_SEQUENCER_FRAME_CNT_EN
    check("frame_cnt_wrap", 32'(frame_cnt), 32'd0);
`endif

    // randomized traffic
    for (int k = 0; k < 3000; k++) begin
      if ($urandom_range(0, 15) == 0) lane_mask = 4'($urandom);
      en = ($urandom_range(0, 39) != 0);
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
